// File: rtl/ast_arb_mux.sv
// ============================================================================
//  Module   : ast_arb_mux
//  Purpose  : Packet-level round-robin arbiter merging RX_DIR Avalon-ST
//             sources onto one sink; grant held from SOP to accepted EOP.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ast_arb_mux #(
  parameter int DATA_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 8,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int RX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [RX_DIR*DATA_WIDTH-1:0]    ast_data_i,
  input  logic [RX_DIR-1:0]               ast_startofpacket_i,
  input  logic [RX_DIR-1:0]               ast_endofpacket_i,
  input  logic [RX_DIR-1:0]               ast_valid_i,
  input  logic [RX_DIR*EMPTY_WIDTH-1:0]   ast_empty_i,
  input  logic [RX_DIR*CHANNEL_WIDTH-1:0] ast_channel_i,
  output logic [RX_DIR-1:0]               ast_ready_o,
  output logic [DATA_WIDTH-1:0]           ast_data_o,
  output logic                            ast_startofpacket_o,
  output logic                            ast_endofpacket_o,
  output logic                            ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]          ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0]        ast_channel_o,
  input  logic                            ast_ready_i,
  output logic [DIR_SEL_WIDTH-1:0]        dir_o
);

  localparam logic [DIR_SEL_WIDTH-1:0] c_LAST = DIR_SEL_WIDTH'(RX_DIR - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                   r_state;
  logic [DIR_SEL_WIDTH-1:0] r_grant;
  logic [DIR_SEL_WIDTH-1:0] r_rr_ptr;

  logic                     w_busy;
  logic                     w_any;
  logic [DIR_SEL_WIDTH-1:0] w_pick;
  logic [DIR_SEL_WIDTH-1:0] w_next_ptr;
  logic                     w_eop_accept;
  logic [RX_DIR-1:0]        w_ready;
  int                       w_gi;
  int                       w_off;
  int                       w_best;

  assign w_busy = (r_state == ST_BUSY);
  assign w_gi   = int'(r_grant);

  // Winner is the valid source with the smallest distance from rr_ptr.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_off  = 0;
    w_best = RX_DIR;
    for (int k = 0; k < RX_DIR; k++) begin
      w_off = (k + RX_DIR - int'(r_rr_ptr)) % RX_DIR;
      if (ast_valid_i[k] && (w_off < w_best)) begin
        w_best = w_off;
        w_pick = DIR_SEL_WIDTH'(k);
        w_any  = 1'b1;
      end
    end
  end

  assign ast_data_o          = ast_data_i[w_gi*DATA_WIDTH +: DATA_WIDTH];
  assign ast_empty_o         = ast_empty_i[w_gi*EMPTY_WIDTH +: EMPTY_WIDTH];
  assign ast_channel_o       = ast_channel_i[w_gi*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  assign ast_startofpacket_o = ast_startofpacket_i[r_grant];
  assign ast_endofpacket_o   = ast_endofpacket_i[r_grant];
  assign ast_valid_o         = w_busy & ast_valid_i[r_grant];
  assign dir_o               = r_grant;

  always_comb begin
    w_ready = '0;
    if (w_busy) begin
      w_ready[r_grant] = ast_ready_i;
    end
  end
  assign ast_ready_o = w_ready;

  assign w_eop_accept = ast_valid_o & ast_ready_i & ast_endofpacket_o;
  assign w_next_ptr   = (r_grant == c_LAST) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_eop_accept) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ast_arb_mux.sv
// ============================================================================
//  Module   : tb_ast_arb_mux
//  Purpose  : Directed self-checking bench for ast_arb_mux (RX_DIR = 4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ast_arb_mux;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int EW = 3;
  localparam int N  = 4;
  localparam int SW = 2;

  logic              clk;
  logic              rst;
  logic [N*DW-1:0]   ast_data_i;
  logic [N-1:0]      ast_startofpacket_i;
  logic [N-1:0]      ast_endofpacket_i;
  logic [N-1:0]      ast_valid_i;
  logic [N*EW-1:0]   ast_empty_i;
  logic [N*CW-1:0]   ast_channel_i;
  logic [N-1:0]      ast_ready_o;
  logic [DW-1:0]     ast_data_o;
  logic              ast_startofpacket_o;
  logic              ast_endofpacket_o;
  logic              ast_valid_o;
  logic [EW-1:0]     ast_empty_o;
  logic [CW-1:0]     ast_channel_o;
  logic              ast_ready_i;
  logic [SW-1:0]     dir_o;

  int errors = 0;
  int checks = 0;

  ast_arb_mux #(
    .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .EMPTY_WIDTH(EW),
    .RX_DIR(N), .DIR_SEL_WIDTH(SW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ast_data_i          (ast_data_i),
    .ast_startofpacket_i (ast_startofpacket_i),
    .ast_endofpacket_i   (ast_endofpacket_i),
    .ast_valid_i         (ast_valid_i),
    .ast_empty_i         (ast_empty_i),
    .ast_channel_i       (ast_channel_i),
    .ast_ready_o         (ast_ready_o),
    .ast_data_o          (ast_data_o),
    .ast_startofpacket_o (ast_startofpacket_o),
    .ast_endofpacket_o   (ast_endofpacket_o),
    .ast_valid_o         (ast_valid_o),
    .ast_empty_o         (ast_empty_o),
    .ast_channel_o       (ast_channel_o),
    .ast_ready_i         (ast_ready_i),
    .dir_o               (dir_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src(input int k, input logic v, input logic s, input logic e,
                     input logic [63:0] d);
    ast_valid_i[k]             = v;
    ast_startofpacket_i[k]     = s;
    ast_endofpacket_i[k]       = e;
    ast_data_i[k*DW +: DW]     = d;
    ast_empty_i[k*EW +: EW]    = EW'(k + 1);
    ast_channel_i[k*CW +: CW]  = CW'(8'h40 + k);
  endtask

  task automatic clr_all();
    for (int k = 0; k < N; k++) src(k, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  // Checks one beat driven by source k on the sink side.
  task automatic chk_beat(input string tag, input int k, input logic [63:0] d,
                          input logic s, input logic e);
    chk({tag, "_valid"}, {63'b0, ast_valid_o}, 64'd1);
    chk({tag, "_dir"},   {62'b0, dir_o}, 64'(k));
    chk({tag, "_data"},  ast_data_o, d);
    chk({tag, "_sop"},   {63'b0, ast_startofpacket_o}, {63'b0, s});
    chk({tag, "_eop"},   {63'b0, ast_endofpacket_o}, {63'b0, e});
  endtask

  initial begin
    logic [3:0] order [5];
    int beat;
    logic r;

    rst = 1'b1;
    ast_ready_i = 1'b0;
    clr_all();
    #2;
    chk("rst_valid", {63'b0, ast_valid_o}, 64'd0);
    chk("rst_ready", {60'b0, ast_ready_o}, 64'd0);
    chk("rst_dir",   {62'b0, dir_o}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single source: src2, 3-beat packet, sink always ready.
    ast_ready_i = 1'b1;
    src(2, 1'b1, 1'b1, 1'b0, 64'hA0);
    #1;
    chk("t1_idle_valid", {63'b0, ast_valid_o}, 64'd0);
    tick();
    chk_beat("t1_b0", 2, 64'hA0, 1'b1, 1'b0);
    chk("t1_ready", {60'b0, ast_ready_o}, 64'b0100);
    chk("t1_empty", {61'b0, ast_empty_o}, 64'd3);
    chk("t1_chan",  {56'b0, ast_channel_o}, 64'h42);
    tick();
    src(2, 1'b1, 1'b0, 1'b0, 64'hA1);
    #1;
    chk_beat("t1_b1", 2, 64'hA1, 1'b0, 1'b0);
    tick();
    src(2, 1'b1, 1'b0, 1'b1, 64'hA2);
    #1;
    chk_beat("t1_b2", 2, 64'hA2, 1'b0, 1'b1);
    tick();
    src(2, 1'b0, 1'b0, 1'b0, 64'h0);
    #1;
    chk("t1_post_valid", {63'b0, ast_valid_o}, 64'd0);
    chk("t1_post_ready", {60'b0, ast_ready_o}, 64'd0);

    // rr_ptr is now 3: single-beat packets from src0 and src3, src3 first.
    src(0, 1'b1, 1'b1, 1'b1, 64'hC0);
    src(3, 1'b1, 1'b1, 1'b1, 64'hC3);
    tick();
    chk_beat("t2_s3", 3, 64'hC3, 1'b1, 1'b1);
    chk("t2_s3_ready", {60'b0, ast_ready_o}, 64'b1000);
    tick();
    src(3, 1'b0, 1'b0, 1'b0, 64'h0);
    #1;
    chk("t2_bubble", {63'b0, ast_valid_o}, 64'd0);
    tick();
    chk_beat("t2_s0", 0, 64'hC0, 1'b1, 1'b1);
    chk("t2_s0_ready", {60'b0, ast_ready_o}, 64'b0001);
    tick();
    clr_all();

    // All sources send 2-beat packets continuously; rr_ptr = 1.
    order[0] = 4'd1; order[1] = 4'd2; order[2] = 4'd3; order[3] = 4'd0; order[4] = 4'd1;
    for (int k = 0; k < N; k++) src(k, 1'b1, 1'b1, 1'b0, 64'(16 * k));
    #1;
    for (int p = 0; p < 5; p++) begin
      chk("t3_gap", {63'b0, ast_valid_o}, 64'd0);
      tick();
      chk_beat("t3_b0", int'(order[p]), 64'(16 * int'(order[p])), 1'b1, 1'b0);
      tick();
      src(int'(order[p]), 1'b1, 1'b0, 1'b1, 64'(16 * int'(order[p]) + 1));
      #1;
      chk_beat("t3_b1", int'(order[p]), 64'(16 * int'(order[p]) + 1), 1'b0, 1'b1);
      tick();
      src(int'(order[p]), 1'b1, 1'b1, 1'b0, 64'(16 * int'(order[p])));
      #1;
    end
    clr_all();

    // Backpressure on a 4-beat packet from src1; rr_ptr = 2.
    beat = 0;
    src(1, 1'b1, 1'b1, 1'b0, 64'hB0);
    tick();
    for (int c = 0; c < 7; c++) begin
      r = (c % 2 == 0);
      ast_ready_i = r;
      src(1, 1'b1, beat == 0, beat == 3, 64'hB0 + 64'(beat));
      #1;
      chk("t4_data",  ast_data_o, 64'hB0 + 64'(beat));
      chk("t4_ready", {60'b0, ast_ready_o}, {60'b0, 2'b00, r, 1'b0});
      tick();
      if (r) beat++;
    end
    src(1, 1'b0, 1'b0, 1'b0, 64'h0);
    ast_ready_i = 1'b1;
    #1;
    chk("t4_released", {63'b0, ast_valid_o}, 64'd0);

    // Reset asserted on beat 2 of a 5-beat src2 packet.
    src(2, 1'b1, 1'b1, 1'b0, 64'hE0);
    tick();
    tick();
    src(2, 1'b1, 1'b0, 1'b0, 64'hE1);
    #1;
    chk_beat("t5_b1", 2, 64'hE1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {63'b0, ast_valid_o}, 64'd0);
    chk("t5_rst_ready", {60'b0, ast_ready_o}, 64'd0);
    chk("t5_rst_dir",   {62'b0, dir_o}, 64'd0);
    tick();
    rst = 1'b0;
    src(0, 1'b1, 1'b1, 1'b1, 64'hF0);
    src(2, 1'b1, 1'b1, 1'b0, 64'hE0);
    tick();
    chk_beat("t5_s0", 0, 64'hF0, 1'b1, 1'b1);
    tick();
    clr_all();

    // Valid gap from src1 while src0 also requests; rr_ptr = 1.
    src(0, 1'b1, 1'b1, 1'b1, 64'h90);
    src(1, 1'b1, 1'b1, 1'b0, 64'hD0);
    tick();
    chk_beat("t6_b0", 1, 64'hD0, 1'b1, 1'b0);
    tick();
    src(1, 1'b0, 1'b0, 1'b0, 64'hD1);
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("t6_gap_valid", {63'b0, ast_valid_o}, 64'd0);
      chk("t6_gap_dir",   {62'b0, dir_o}, 64'd1);
      chk("t6_gap_ready", {60'b0, ast_ready_o}, 64'b0010);
      tick();
    end
    src(1, 1'b1, 1'b0, 1'b1, 64'hD1);
    #1;
    chk_beat("t6_b1", 1, 64'hD1, 1'b0, 1'b1);
    tick();
    src(1, 1'b0, 1'b0, 1'b0, 64'h0);
    #1;
    chk("t6_bubble", {63'b0, ast_valid_o}, 64'd0);
    tick();
    chk_beat("t6_s0", 0, 64'h90, 1'b1, 1'b1);
    tick();
    clr_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
